code_nco_sched: RTL

- Tracking-channel controller for the code NCO: schedules software-written frequency words and half-chip slews so both take effect only on TIC boundaries.
- Sits between the bus register block and the code NCO/code generator pair.
- Drives the NCO's `f_control`.
- Gates the NCO's `hc_enable` pulses before they reach the code generator, which implements code-phase slew.

---
 rtl/code_nco_pkg.sv | 14 +
 rtl/code_nco_sched_if.sv | 25 ++
 rtl/code_nco_sched.sv | 98 +++++++++
 3 files changed

// File: rtl/code_nco_pkg.sv
// Shared constants and slew state encoding for the code NCO tracking-channel scheduler.
package code_nco_pkg;

  localparam int FW = 28;
  localparam int SW = 11;
  localparam logic [FW-1:0] F_RESET = 28'h0A79BBB;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SLEWING
  } slew_state_e;

endpackage

// File: rtl/code_nco_sched_if.sv
// Register-block side of the code NCO scheduler: write strobes in, status flags out.
interface code_nco_sched_if #(
  parameter int FW = code_nco_pkg::FW,
  parameter int SW = code_nco_pkg::SW
);

  logic          wr_freq;
  logic [FW-1:0] wr_freq_data;
  logic          wr_slew;
  logic [SW-1:0] wr_slew_data;
  logic          freq_pending;
  logic          slew_busy;
  logic          slew_done;

  modport master (
    output wr_freq, wr_freq_data, wr_slew, wr_slew_data,
    input  freq_pending, slew_busy, slew_done
  );

  modport slave (
    input  wr_freq, wr_freq_data, wr_slew, wr_slew_data,
    output freq_pending, slew_busy, slew_done
  );

endinterface

// File: rtl/code_nco_sched.sv
// Code NCO scheduler: frequency words and half-chip slews written by software take
// effect only on TIC boundaries; slews are applied by dropping hc_enable pulses.
module code_nco_sched #(
  parameter int            FW      = code_nco_pkg::FW,
  parameter int            SW      = code_nco_pkg::SW,
  parameter logic [FW-1:0] F_RESET = code_nco_pkg::F_RESET
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tic_enable,
  input  logic          hc_enable_in,
  output logic [FW-1:0] f_control,
  output logic          hc_enable_out,
  code_nco_sched_if.slave bus
);

  import code_nco_pkg::*;

  logic [FW-1:0] shadow;
  slew_state_e   state, state_nxt;
  logic [SW-1:0] slew_cnt, slew_cnt_nxt;
  logic          done_nxt;

  // Frequency shadow: a write coincident with a TIC lands in the shadow while the
  // TIC still applies the previously pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_control        <= F_RESET;
      shadow           <= F_RESET;
      bus.freq_pending <= 1'b0;
    end else begin
      if (tic_enable && bus.freq_pending)
        f_control <= shadow;
      if (bus.wr_freq) begin
        shadow           <= bus.wr_freq_data;
        bus.freq_pending <= 1'b1;
      end else if (tic_enable) begin
        bus.freq_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    slew_cnt_nxt = slew_cnt;
    done_nxt     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.wr_slew && (bus.wr_slew_data != '0)) begin
          slew_cnt_nxt = bus.wr_slew_data;
          state_nxt    = ARMED;
        end
      end
      ARMED: begin
        if (bus.wr_slew && (bus.wr_slew_data == '0)) begin
          slew_cnt_nxt = '0;
          state_nxt    = IDLE;
        end else begin
          if (bus.wr_slew)
            slew_cnt_nxt = bus.wr_slew_data;
          if (tic_enable)
            state_nxt = SLEWING;
        end
      end
      SLEWING: begin
        if (hc_enable_in && (slew_cnt != '0)) begin
          slew_cnt_nxt = slew_cnt - {{(SW-1){1'b0}}, 1'b1};
          if (slew_cnt == {{(SW-1){1'b0}}, 1'b1}) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        slew_cnt_nxt = '0;
      end
    endcase
  end

  // Slew state and registered outputs; every pulse seen while SLEWING is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      slew_cnt      <= '0;
      hc_enable_out <= 1'b0;
      bus.slew_done <= 1'b0;
      bus.slew_busy <= 1'b0;
    end else begin
      state         <= state_nxt;
      slew_cnt      <= slew_cnt_nxt;
      hc_enable_out <= hc_enable_in & (state != SLEWING);
      bus.slew_done <= done_nxt;
      bus.slew_busy <= (state_nxt != IDLE);
    end
  end

endmodule
